// File: rtl/bv_check_pkg.sv
// bv_check_pkg
// Shared definitions for the bvsgt/bvmul witness checker.
//   chk_state_t      : checker FSM state encoding
//   BV_WIDTH_DEFAULT : default operand/witness width
//   bv_sgt()         : two's-complement "greater than" on the low 'width' bits
// Build option: BVSGT_WITNESS_SEARCH_EN adds the SRCH state.
package bv_check_pkg;

  localparam int BV_WIDTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    CMP  = 3'd2,
`ifdef BVSGT_WITNESS_SEARCH_EN
    SRCH = 3'd4,
`endif
    DONE = 3'd3
  } chk_state_t;

  // Flipping the sign bit of both operands turns a signed compare into an
  // unsigned one, which avoids any width-dependent sign extension.
  function automatic logic bv_sgt(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input int width);
    logic [31:0] msk;
    logic [31:0] sgn;
    msk = (32'd1 << width) - 32'd1;
    sgn = 32'd1 << (width - 1);
    return ((a & msk) ^ sgn) > ((b & msk) ^ sgn);
  endfunction

endpackage

// File: rtl/bvmul_serial.sv
// bvmul_serial
// Serial shift-add multiplier, one multiplier bit per cycle, LSB first.
// The product is truncated to WIDTH bits and held until the next start.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : load a/b and clear the accumulator (ignored state of busy)
//   a, b     : multiplicand, multiplier
//   done     : one-cycle pulse once the last multiplier bit is consumed
//   product  : (a*b) mod 2^WIDTH, valid from the done pulse on
module bvmul_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             busy;

  // a_q walks left and b_q walks right so that bit k of the multiplier
  // always meets the multiplicand already shifted by k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_q     <= a;
        b_q     <= b;
        cnt     <= '0;
        busy    <= 1'b1;
        product <= '0;
      end else if (busy) begin
        if (b_q[0]) begin
          product <= product + a_q;
        end
        a_q <= a_q << 1;
        b_q <= b_q >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bvsgt_bvmul_witness_checker.sv
// bvsgt_bvmul_witness_checker
// Checks a witness x from the find_inv_bvsgt_bvmul Skolem function:
// ok = (x*s mod 2^WIDTH) >s t. With BVSGT_WITNESS_SEARCH_EN defined, a
// failing witness triggers an exhaustive search over all candidates so
// that err flags a Skolem output that missed an existing solution.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (in_ready only in IDLE)
//   s, t, x             : multiplicand, signed threshold, witness
//   out_valid/out_ready : result handshake, result held until consumed
//   ok, exists, err     : witness valid, some witness exists, exists & ~ok
module bvsgt_bvmul_witness_checker
  import bv_check_pkg::*;
#(
  parameter int WIDTH = BV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ok,
  output logic             exists,
  output logic             err
);

  chk_state_t       state;
  chk_state_t       state_nxt;
  logic [WIDTH-1:0] t_q;
  logic             mul_start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;
  logic             pass;

`ifdef BVSGT_WITNESS_SEARCH_EN
  logic [WIDTH-1:0] s_q;
  // One extra bit so that stepping past the last candidate is visible.
  logic [WIDTH:0]   cand;
  logic [WIDTH:0]   cand_inc;

  assign cand_inc = cand + 1'b1;
`endif

  assign pass = bv_sgt(32'(mul_p), 32'(t_q), WIDTH);

  // The single multiplier serves the witness product and every search
  // candidate; operands are only taken from the ports on acceptance.
  bvmul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .done    (mul_done),
    .product (mul_p)
  );

  // Next-state logic and multiplier launch control.
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    mul_a     = s;
    mul_b     = x;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          mul_start = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL: begin
        if (mul_done) begin
          state_nxt = CMP;
        end
      end
      CMP: begin
`ifdef BVSGT_WITNESS_SEARCH_EN
        if (pass) begin
          state_nxt = DONE;
        end else begin
          mul_start = 1'b1;
          mul_a     = s_q;
          mul_b     = '0;
          state_nxt = SRCH;
        end
`else
        state_nxt = DONE;
`endif
      end
`ifdef BVSGT_WITNESS_SEARCH_EN
      SRCH: begin
        mul_a = s_q;
        mul_b = cand_inc[WIDTH-1:0];
        if (mul_done) begin
          if (pass || cand_inc[WIDTH]) begin
            state_nxt = DONE;
          end else begin
            mul_start = 1'b1;
          end
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      ok        <= 1'b0;
      exists    <= 1'b0;
      t_q       <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (state == IDLE && in_valid && in_ready) begin
        t_q <= t;
      end
      if (state == CMP) begin
        ok     <= pass;
        exists <= pass;
      end
`ifdef BVSGT_WITNESS_SEARCH_EN
      if (state == SRCH && mul_done && pass) begin
        exists <= 1'b1;
      end
`endif
    end
  end

`ifdef BVSGT_WITNESS_SEARCH_EN
  // Search bookkeeping; err can only rise when the witness itself failed
  // and some later candidate passed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q  <= '0;
      cand <= '0;
      err  <= 1'b0;
    end else begin
      if (state == IDLE && in_valid && in_ready) begin
        s_q <= s;
      end
      if (state == CMP) begin
        cand <= '0;
        err  <= 1'b0;
      end
      if (state == SRCH && mul_done) begin
        if (pass) begin
          err <= 1'b1;
        end else if (!cand_inc[WIDTH]) begin
          cand <= cand_inc;
        end
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
